rbm_iteration_scheduler: RTL and testbench
==========================================

Name: rbm_iteration_scheduler

Overview:
- Sequences repeated stochastic passes of the hidden/classify RBMLayer pair for one input sample.
- Pulses the layers' internal reset and holds data_valid for each pass, then accumulates per-class spike votes.
- After the last pass, does a sequential argmax over the votes and returns a class label on a valid/ready handshake.
- Sits between the sample source and the layer pair; replaces ad-hoc iteration logic at the top level and adds timeout and error reporting.

Parameters:
- output_dim, 10, number of classes (classify-layer outputs).
- w_bitlength, 12, width of each vote counter; counters saturate at 2^w_bitlength-1.
- iteration_num, 30, passes per sample; legal range 1..1023; elaboration $error if 0.
- label_bitlength, 4, label width; must satisfy 2^label_bitlength >= output_dim.
- timeout_cycles, 4096, maximum cycles in RUN before a pass is declared hung; legal range 1..65535.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request to classify the currently presented sample; accepted only in IDLE.
- busy  output  1  high in every state except IDLE.
- layer_reset  output  1  drives the layers' internal reset, active-high.
- layer_data_valid  output  1  drives the hidden layer's data_valid.
- layer_finish  input  1  classify-layer finish.
- layer_spikes  input  output_dim  classify-layer binary outputs; bit g = class g.
- votes  output  output_dim*w_bitlength  vote counters, class g at bits [g*w_bitlength +: w_bitlength].
- iter_count  output  10  completed passes for the current sample.
- label  output  label_bitlength  winning class index.
- label_valid  output  1  label/votes/timeout_err valid.
- label_ready  input  1  consumer accepts the label.
- timeout_err  output  1  current result was aborted by timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0; layer_reset=1; layer_data_valid=0; votes=0; iter_count=0; label=0; label_valid=0; timeout_err=0; internal cycle counter=0.
- All outputs are registered. A state is named by where the FSM sits during a given cycle.
- IDLE:
  - layer_reset held 1.
  - start=1 -> ARM; on that edge clear votes, iter_count and timeout_err.
  - start is ignored in every other state; no queueing.
- ARM (1 cycle): layer_reset=1, layer_data_valid=0. layer_finish is ignored. Next state is RUN; the cycle counter is cleared.
- RUN:
  - layer_reset=0, layer_data_valid=1; the cycle counter increments every cycle.
  - layer_finish=1 -> ACCUM; layer_spikes is captured on that same edge.
  - If the counter reaches timeout_cycles-1 with layer_finish=0 -> ERR.
  - If finish and timeout coincide, finish wins.
- ACCUM (1 cycle):
  - For each g with captured spike=1, votes[g] += 1, saturating at all-ones.
  - iter_count += 1.
  - If the new iter_count == iteration_num -> SCAN, otherwise -> ARM.
  - layer_reset=1 and layer_data_valid=0 in this cycle.
- SCAN (exactly output_dim cycles):
  - Index i steps 0..output_dim-1, one per cycle.
  - A running max and index are updated only when votes[i] > max (strictly greater), so the lowest index wins ties.
  - All-zero votes give label=0.
  - After the last index -> DONE with label loaded; layer_reset=1.
- ERR (1 cycle): label=0, timeout_err=1, votes keep their partial counts, layer_reset=1 -> DONE.
- DONE:
  - label_valid=1, and label, votes, timeout_err, iter_count are stable.
  - label_ready=1 -> IDLE with label_valid=0 on that edge. votes and label keep their values until the next accepted start.
  - label_ready high in any other state has no effect.
- Latency, no timeout: let F = RUN cycles per pass, including the finish cycle. Cycles from start accepted to label_valid rising = iteration_num*(2+F) + output_dim + 1.
- Reset mid-operation: immediate return to the reset values. layer_reset=1 forces the layers idle, and no partial result survives.
- Spikes are never sampled outside the RUN finish edge, so a stale layer_finish during ARM/ACCUM/SCAN/DONE has no effect.

Test Plan:
- Reset, then start; layers finish after 5 RUN cycles with layer_spikes=10'b0000001000 every pass, iteration_num=30 -> votes[3]=30, others 0; label=3; timeout_err=0; label_valid rises 30*7+10+1=221 cycles after start.
- Ties: passes alternate spikes 10'b0000100010 and 10'b0000100000 (30 passes) -> votes[1]=15, votes[5]=30, label=5. Repeat with both classes equal at 15 -> label=1, the lower index.
- Timeout: timeout_cycles=16, layer_finish stuck 0 in pass 3 after two good passes of class 7 -> ERR reached 16 cycles into RUN; label_valid=1, timeout_err=1, label=0, votes[7]=2, iter_count=2.
- Handshake: hold label_ready=0 for 20 cycles in DONE -> outputs stable, start pulses ignored. Raise label_ready -> IDLE next edge, label_valid=0. A subsequent start clears votes.
- Saturation: w_bitlength=4, iteration_num=20, spikes all-ones -> every votes[g]=15, label=0.
- Async reset (reset=0) asserted mid-RUN in pass 10 -> all outputs at reset values immediately, layer_reset=1. After release, start runs a clean 30-pass sample.

Source files
------------

// File: rtl/rbm_iteration_scheduler.sv
// Drives repeated stochastic passes of the hidden/classify RBM layer pair for one sample,
// accumulates per-class spike votes, then returns the argmax class on a valid/ready port.
module rbm_iteration_scheduler #(
    parameter int output_dim      = 10,
    parameter int w_bitlength     = 12,
    parameter int iteration_num   = 30,
    parameter int label_bitlength = 4,
    parameter int timeout_cycles  = 4096
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                layer_reset,
    output logic                                layer_data_valid,
    input  logic                                layer_finish,
    input  logic [output_dim-1:0]               layer_spikes,
    output logic [output_dim*w_bitlength-1:0]   votes,
    output logic [9:0]                          iter_count,
    output logic [label_bitlength-1:0]          label,
    output logic                                label_valid,
    input  logic                                label_ready,
    output logic                                timeout_err,
    output logic [2:0]                          state_dbg
);

    if (iteration_num < 1 || iteration_num > 1023) begin : g_chk_iter
        $error("rbm_iteration_scheduler: iteration_num must be 1..1023");
    end
    if ((1 << label_bitlength) < output_dim) begin : g_chk_label
        $error("rbm_iteration_scheduler: label_bitlength too narrow for output_dim");
    end
    if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_chk_timeout
        $error("rbm_iteration_scheduler: timeout_cycles must be 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        ACCUM = 3'd3,
        SCAN  = 3'd4,
        ERR   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [w_bitlength-1:0]     VOTE_MAX  = '1;
    localparam logic [9:0]                 ITER_LAST = 10'(iteration_num);
    localparam logic [15:0]                TO_LAST   = 16'(timeout_cycles - 1);
    localparam logic [label_bitlength-1:0] SCAN_LAST = label_bitlength'(output_dim - 1);

    state_t                      state, state_n;
    logic [15:0]                 run_cnt;
    logic [output_dim-1:0]       spikes_q;
    logic [w_bitlength-1:0]      vote_q [output_dim];
    logic [label_bitlength-1:0]  scan_idx, scan_arg;
    logic [w_bitlength-1:0]      scan_max;
    logic [9:0]                  iter_inc;
    logic                        scan_hit;

    assign state_dbg = state;

    for (genvar g = 0; g < output_dim; g++) begin : g_votes
        assign votes[g*w_bitlength +: w_bitlength] = vote_q[g];
    end

    always_comb begin
        state_n  = state;
        iter_inc = iter_count + 10'd1;
        // Strictly-greater compare keeps the lowest index on ties.
        scan_hit = vote_q[scan_idx] > scan_max;
        case (state)
            IDLE:    if (start) state_n = ARM;
            ARM:     state_n = RUN;
            RUN: begin
                if (layer_finish)            state_n = ACCUM;
                else if (run_cnt == TO_LAST) state_n = ERR;
            end
            ACCUM:   state_n = (iter_inc == ITER_LAST) ? SCAN : ARM;
            SCAN:    if (scan_idx == SCAN_LAST) state_n = DONE;
            ERR:     state_n = DONE;
            DONE:    if (label_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Result handshake: label_valid stays high in DONE with label/votes/iter_count/timeout_err
    // frozen; the transfer happens on the rising edge where label_valid and label_ready are both 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            layer_reset      <= 1'b1;
            layer_data_valid <= 1'b0;
            label_valid      <= 1'b0;
            timeout_err      <= 1'b0;
            label            <= '0;
            iter_count       <= '0;
            run_cnt          <= '0;
            spikes_q         <= '0;
            scan_idx         <= '0;
            scan_arg         <= '0;
            scan_max         <= '0;
            for (int g = 0; g < output_dim; g++) vote_q[g] <= '0;
        end else begin
            state            <= state_n;
            busy             <= (state_n != IDLE);
            layer_reset      <= (state_n != RUN);
            layer_data_valid <= (state_n == RUN);
            label_valid      <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_count  <= '0;
                        timeout_err <= 1'b0;
                        label       <= '0;
                        for (int g = 0; g < output_dim; g++) vote_q[g] <= '0;
                    end
                end
                ARM: run_cnt <= '0;
                RUN: begin
                    run_cnt <= run_cnt + 16'd1;
                    if (layer_finish) begin
                        spikes_q <= layer_spikes;
                    end else if (run_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        label       <= '0;
                    end
                end
                ACCUM: begin
                    for (int g = 0; g < output_dim; g++) begin
                        if (spikes_q[g] && vote_q[g] != VOTE_MAX) vote_q[g] <= vote_q[g] + 1'b1;
                    end
                    iter_count <= iter_inc;
                    scan_idx   <= '0;
                    scan_arg   <= '0;
                    scan_max   <= '0;
                end
                SCAN: begin
                    if (scan_hit) begin
                        scan_max <= vote_q[scan_idx];
                        scan_arg <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == SCAN_LAST) label <= scan_hit ? scan_idx : scan_arg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rbm_iteration_scheduler.sv
// Bench for rbm_iteration_scheduler: randomized layer responder, pass-plan reference model,
// scoreboard queue with a decoupled result monitor, plus a small saturation instance.
module tb_rbm_iteration_scheduler;

    localparam int OD = 10, W = 12, ITER = 30, LB = 4, TO = 16;
    localparam int BW = 4, BITER = 20;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT A (main) ----------------
    logic              start = 1'b0, busy, layer_reset, layer_data_valid;
    logic              layer_finish;
    logic [OD-1:0]     layer_spikes;
    logic [OD*W-1:0]   votes;
    logic [9:0]        iter_count;
    logic [LB-1:0]     label;
    logic              label_valid, label_ready, timeout_err;
    logic [2:0]        state_dbg;

    rbm_iteration_scheduler #(.output_dim(OD), .w_bitlength(W), .iteration_num(ITER),
                              .label_bitlength(LB), .timeout_cycles(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy),
        .layer_reset(layer_reset), .layer_data_valid(layer_data_valid),
        .layer_finish(layer_finish), .layer_spikes(layer_spikes), .votes(votes),
        .iter_count(iter_count), .label(label), .label_valid(label_valid),
        .label_ready(label_ready), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // ---------------- DUT B (narrow counters) ----------------
    logic              b_start = 1'b0, b_busy, b_layer_reset, b_layer_data_valid;
    logic              b_layer_finish;
    logic [OD-1:0]     b_layer_spikes;
    logic [OD*BW-1:0]  b_votes;
    logic [9:0]        b_iter_count;
    logic [LB-1:0]     b_label;
    logic              b_label_valid, b_label_ready, b_timeout_err;
    logic [2:0]        b_state_dbg;

    rbm_iteration_scheduler #(.output_dim(OD), .w_bitlength(BW), .iteration_num(BITER),
                              .label_bitlength(LB), .timeout_cycles(TO)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .busy(b_busy),
        .layer_reset(b_layer_reset), .layer_data_valid(b_layer_data_valid),
        .layer_finish(b_layer_finish), .layer_spikes(b_layer_spikes), .votes(b_votes),
        .iter_count(b_iter_count), .label(b_label), .label_valid(b_label_valid),
        .label_ready(b_label_ready), .timeout_err(b_timeout_err), .state_dbg(b_state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [OD*W-1:0] votes;
        logic [9:0]      iter;
        logic [LB-1:0]   label;
        logic            terr;
        logic [31:0]     done_cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [OD*BW-1:0]  b_exp_q[$];
    int checks = 0, failures = 0, proto_err = 0;
    int hold_req = -1;

    // Pass plan: spikes delivered on each pass and RUN length F (0 = layer never finishes).
    logic [OD-1:0] plan_spk [ITER];
    int            plan_f   [ITER];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: votes are saturated pass counts, label is the lowest index of the maximum,
    // latency is the sum of (2+F) per pass plus the scan (or ERR) tail.
    function automatic exp_t model(input int unsigned s);
        exp_t e;
        int cnt[OD];
        int lat, hang, best;
        e = '0; lat = 0; hang = -1;
        for (int g = 0; g < OD; g++) cnt[g] = 0;
        for (int p = 0; p < ITER; p++) begin
            if (plan_f[p] == 0) begin hang = p; break; end
            lat += 2 + plan_f[p];
            for (int g = 0; g < OD; g++) if (plan_spk[p][g]) cnt[g]++;
        end
        for (int g = 0; g < OD; g++) begin
            if (cnt[g] > (1 << W) - 1) cnt[g] = (1 << W) - 1;
            e.votes[g*W +: W] = W'(cnt[g]);
        end
        if (hang >= 0) begin
            e.iter = 10'(hang); e.terr = 1'b1; e.label = '0;
            lat += 1 + TO + 1 + 1;
        end else begin
            best = 0;
            for (int g = 1; g < OD; g++) if (cnt[g] > cnt[best]) best = g;
            e.iter = 10'(ITER); e.terr = 1'b0; e.label = LB'(best);
            lat += OD + 1;
        end
        e.done_cyc = s + 32'(lat);
        return e;
    endfunction

    // ---------------- layer responders ----------------
    int pass_idx = 0, run_cnt = 0;
    initial begin
        int cur_f;
        layer_finish = 1'b0; layer_spikes = '0;
        forever begin
            @(negedge clock);
            if (!busy) begin
                pass_idx = 0; run_cnt = 0;
            end else if (!layer_data_valid && run_cnt != 0) begin
                pass_idx++; run_cnt = 0;
            end
            if (layer_data_valid == layer_reset) proto_err++;
            if (layer_data_valid) begin
                if (!busy) proto_err++;
                run_cnt++;
                cur_f = (pass_idx < ITER) ? plan_f[pass_idx] : 0;
                if (cur_f != 0 && run_cnt == cur_f) begin
                    layer_finish = 1'b1; layer_spikes = plan_spk[pass_idx];
                end else begin
                    layer_finish = 1'b0; layer_spikes = OD'($urandom);
                end
            end else begin
                // stale finish/spikes outside RUN must be ignored
                layer_finish = 1'($urandom_range(0, 1)); layer_spikes = OD'($urandom);
            end
        end
    end

    initial begin
        b_layer_finish = 1'b0; b_layer_spikes = '0;
        forever begin
            @(negedge clock);
            b_layer_finish = b_layer_data_valid ? 1'b1 : 1'($urandom_range(0, 1));
            b_layer_spikes = b_layer_data_valid ? '1 : OD'($urandom);
        end
    end

    // ---------------- monitors ----------------
    initial begin
        exp_t e;
        int   hold;
        bit   stable_ok;
        label_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (label_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_label actual=label_valid expected=no_result");
                end else begin
                    e = exp_q.pop_front();
                    chk("votes", votes, e.votes);
                    chk("label", label, e.label);
                    chk("iter_count", iter_count, e.iter);
                    chk("timeout_err", timeout_err, e.terr);
                    chk("latency", cyc, e.done_cyc);
                    hold = (hold_req >= 0) ? hold_req : $urandom_range(0, 20);
                    stable_ok = 1'b1;
                    repeat (hold) begin
                        @(negedge clock);
                        if (!(label_valid && busy && votes == e.votes && label == e.label &&
                              iter_count == e.iter && timeout_err == e.terr)) stable_ok = 1'b0;
                    end
                    chk("done_stable", stable_ok, 1'b1);
                    label_ready = 1'b1;
                    @(negedge clock);
                    label_ready = 1'b0;
                    chk("handshake", {label_valid, busy, votes, label}, {2'b00, e.votes, e.label});
                end
            end
        end
    end

    initial begin
        logic [OD*BW-1:0] be;
        b_label_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (b_label_valid) begin
                if (b_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected_label actual=label_valid expected=no_result");
                end else begin
                    be = b_exp_q.pop_front();
                    chk("sat_votes", b_votes, be);
                    chk("sat_label", b_label, '0);
                    chk("sat_iter", b_iter_count, 10'(BITER));
                    chk("sat_terr", b_timeout_err, 1'b0);
                    b_label_ready = 1'b1;
                    @(negedge clock);
                    b_label_ready = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_layer_reset"}, layer_reset, 1'b1);
        chk({tag, "_layer_dv"}, layer_data_valid, 1'b0);
        chk({tag, "_votes"}, votes, '0);
        chk({tag, "_iter_lbl"}, {iter_count, label}, '0);
        chk({tag, "_lv_terr"}, {label_valid, timeout_err}, 2'b00);
    endtask

    task automatic plan_random(input int hang_at);
        for (int p = 0; p < ITER; p++) begin
            plan_spk[p] = OD'($urandom);
            plan_f[p]   = $urandom_range(1, 16);
        end
        if (hang_at >= 0) plan_f[hang_at] = 0;
    endtask

    task automatic run_txn(input bit abort_mid);
        int n;
        n = 0;
        while ((busy || label_valid) && n < 200) begin @(negedge clock); n++; end
        chk("idle_wait_bound", n < 200, 1'b1);
        exp_q.push_back(model(cyc));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("arm_clear", {busy, layer_reset, layer_data_valid, timeout_err, iter_count, votes},
            {3'b110, 1'b0, 10'd0, {OD*W{1'b0}}});
        if (abort_mid) begin
            n = 0;
            while (!(layer_data_valid && pass_idx == 9) && n < 2000) begin @(negedge clock); n++; end
            chk("abort_wait_bound", n < 2000, 1'b1);
            #2 reset = 1'b0;
            #1 check_reset_values("async_reset");
            void'(exp_q.pop_back());
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
        end else begin
            n = 0;
            while (!(exp_q.size() == 0 && !busy && !label_valid) && n < 3000) begin
                @(negedge clock);
                n++;
                start = label_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            start = 1'b0;
            chk("done_wait_bound", n < 3000, 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [OD*BW-1:0] bexp;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // saturation on the narrow instance: 20 all-ones passes into 4-bit counters
        for (int g = 0; g < OD; g++) bexp[g*BW +: BW] = BW'((BITER > 15) ? 15 : BITER);
        b_exp_q.push_back(bexp);
        b_start = 1'b1;
        @(negedge clock);
        b_start = 1'b0;
        n = 0;
        while ((b_exp_q.size() != 0 || b_busy) && n < 2000) begin @(negedge clock); n++; end
        chk("b_done_wait_bound", n < 2000, 1'b1);

        // single class every pass, F=5: 221-cycle latency
        for (int p = 0; p < ITER; p++) begin plan_spk[p] = OD'(10'b0000001000); plan_f[p] = 5; end
        run_txn(1'b0);

        // alternating classes 1+5 / 5
        for (int p = 0; p < ITER; p++) begin
            plan_spk[p] = (p % 2 == 0) ? OD'(10'b0000100010) : OD'(10'b0000100000);
            plan_f[p]   = $urandom_range(1, 16);
        end
        run_txn(1'b0);

        // exact tie 15/15 -> lower index
        for (int p = 0; p < ITER; p++) begin
            plan_spk[p] = (p % 2 == 0) ? OD'(10'b0000000010) : OD'(10'b0000100000);
            plan_f[p]   = $urandom_range(1, 16);
        end
        run_txn(1'b0);

        // timeout in pass 3 after two class-7 passes, long hold in DONE
        plan_random(2);
        plan_spk[0] = OD'(10'b0010000000);
        plan_spk[1] = OD'(10'b0010000000);
        hold_req = 20;
        run_txn(1'b0);
        hold_req = -1;

        // async reset in the middle of pass 10, then a clean sample
        plan_random(-1);
        plan_f[9] = 12;
        run_txn(1'b1);
        plan_random(-1);
        run_txn(1'b0);

        // all-zero votes
        for (int p = 0; p < ITER; p++) begin plan_spk[p] = '0; plan_f[p] = $urandom_range(1, 16); end
        run_txn(1'b0);

        // finish coincides with the timeout boundary on every pass
        plan_random(-1);
        for (int p = 0; p < ITER; p++) plan_f[p] = TO;
        run_txn(1'b0);

        for (int t = 0; t < 4; t++) begin
            plan_random(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ITER - 1)) : -1);
            run_txn(1'b0);
        end

        repeat (3) @(negedge clock);
        chk("protocol_violations", 32'(proto_err), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
